// File: rtl/clock_divider_bank.sv
// clock_divider_bank
//   Bank of N independent programmable dividers running from one clock.
//   Each channel outputs a 50% duty divided clock (period 2*(D+1) input
//   cycles) and a one-cycle tick every D+1 input cycles. A new divisor only
//   becomes active at a period boundary, so the divided clocks never glitch.
//   A global sync_restart puts every channel back to phase zero on one edge.
//
// Ports
//   clk_in          system clock, all logic on its rising edge
//   rst_n           asynchronous active-low reset
//   cfg_we          configuration write strobe (one cycle)
//   cfg_chan        channel addressed by the write; out-of-range is ignored
//   cfg_div         divisor D for the channel's pending register
//   cfg_en          enable bit for the channel, written together with cfg_div
//   sync_restart    one-cycle pulse, restarts all channels in phase
//   clk_out[N]      registered divided clocks
//   tick[N]         registered one-cycle strobes
//   active_div_ch0  divisor currently in use by channel 0 (debug view)
//
// Handshake: cfg_we is a valid-only strobe. The bank is always ready, so
// every cycle with cfg_we high is accepted on that same rising edge; there
// is no back-pressure and no ready output.
module clock_divider_bank #(
  parameter int                     N_CHANNELS  = 4,
  parameter int                     CNT_WIDTH   = 32,
  parameter logic [CNT_WIDTH-1:0]   DEFAULT_DIV = CNT_WIDTH'(49_999_999),
  parameter logic [N_CHANNELS-1:0]  DEFAULT_EN  = {N_CHANNELS{1'b1}},
  // Derived from N_CHANNELS; not meant to be overridden.
  parameter int                     CHAN_W      = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [CHAN_W-1:0]     cfg_chan,
  input  logic [CNT_WIDTH-1:0]  cfg_div,
  input  logic                  cfg_en,
  input  logic                  sync_restart,
  output logic [N_CHANNELS-1:0] clk_out,
  output logic [N_CHANNELS-1:0] tick,
  output logic [CNT_WIDTH-1:0]  active_div_ch0
);

  for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_ch
    localparam logic [CHAN_W-1:0] IDX = CHAN_W'(gi);

    logic                 r_en;
    logic [CNT_WIDTH-1:0] r_pend;
    logic [CNT_WIDTH-1:0] r_act;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_clk;
    logic                 r_tick;

    logic w_wr;
    logic w_hold;
    logic w_term;

    // Addresses at or above N_CHANNELS match no IDX, so they are dropped.
    assign w_wr   = cfg_we && (cfg_chan == IDX);
    // Restart and disable share one behaviour: park at phase zero and keep
    // active_div tracking pending, so the next run starts with the new D.
    assign w_hold = sync_restart || !r_en;
    // Equality is enough: active_div only changes while the counter is (or
    // is being forced to) zero, so the counter can never pass it.
    assign w_term = (r_cnt == r_act);

    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        r_en   <= DEFAULT_EN[gi];
        r_pend <= DEFAULT_DIV;
        r_act  <= DEFAULT_DIV;
        r_cnt  <= '0;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
      end else begin
        // The write lands in pending/en; the counting logic below still sees
        // the pre-edge values, which gives the one-period divisor latency and
        // the next-edge enable latency.
        if (w_wr) begin
          r_pend <= cfg_div;
          r_en   <= cfg_en;
        end
        if (w_hold) begin
          r_cnt  <= '0;
          r_clk  <= 1'b0;
          r_tick <= 1'b0;
          r_act  <= r_pend;
        end else if (w_term) begin
          r_cnt  <= '0;
          r_clk  <= ~r_clk;
          r_tick <= 1'b1;
          r_act  <= r_pend;
        end else begin
          r_cnt  <= r_cnt + CNT_WIDTH'(1);
          r_tick <= 1'b0;
        end
      end
    end

    assign clk_out[gi] = r_clk;
    assign tick[gi]    = r_tick;

    if (gi == 0) begin : g_dbg
      assign active_div_ch0 = r_act;
    end
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Testbench for clock_divider_bank: three channels, default divisor 3.
// The driver pushes the outputs it expects after each edge into exp_q; the
// monitor pops them on the falling edge following that rising edge.
module tb_clock_divider_bank;

  localparam int NCH = 3;
  localparam int CW  = 32;
  localparam int CHW = 2;
  // Queue entry: {due edge[15:0], active_div_ch0[31:0], tick[2:0], clk_out[2:0]}
  localparam int W   = 54;

  // ---------------- clock / reset ----------------
  logic           clk_in       = 1'b0;
  logic           rst_n        = 1'b0;
  logic           cfg_we       = 1'b0;
  logic [CHW-1:0] cfg_chan     = '0;
  logic [CW-1:0]  cfg_div      = '0;
  logic           cfg_en       = 1'b0;
  logic           sync_restart = 1'b0;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
  logic [CW-1:0]  active_div_ch0;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  string        name_q[$];

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;

  clock_divider_bank #(
    .N_CHANNELS  (NCH),
    .CNT_WIDTH   (CW),
    .DEFAULT_DIV (32'd3),
    .DEFAULT_EN  (3'b111)
  ) dut (
    .clk_in         (clk_in),
    .rst_n          (rst_n),
    .cfg_we         (cfg_we),
    .cfg_chan       (cfg_chan),
    .cfg_div        (cfg_div),
    .cfg_en         (cfg_en),
    .sync_restart   (sync_restart),
    .clk_out        (clk_out),
    .tick           (tick),
    .active_div_ch0 (active_div_ch0)
  );

  // ---------------- expected waveforms ----------------
  // {clk,tick} of a free-running channel m edges after its phase-zero edge,
  // divisor d, clock starting at level ph.
  function automatic logic [1:0] per(int m, int d, int ph);
    logic [1:0] r;
    r[0] = (m > 0) && ((m % (d + 1)) == 0);
    r[1] = (((m / (d + 1)) + ph) % 2) == 1;
    return r;
  endfunction

  // Hand-derived timeline. Epoch 0: first run with the directed writes;
  // epoch 1: defaults again after the asynchronous reset. n = edges since
  // reset release.
  function automatic logic [37:0] exp_vec(int ep, int n);
    logic [1:0]  c0;
    logic [1:0]  c1;
    logic [1:0]  c2;
    logic [31:0] a;
    if (ep == 1) begin
      c0 = per(n, 3, 0);
      c1 = c0;
      c2 = c0;
      a  = 32'd3;
    end else begin
      // ch0: D=3, disabled at 23..27 (written D=2), running from 27,
      // restart at 33, D=0 written at terminal 48 -> active from 51,
      // restart at 61.
      if      (n <= 22) c0 = per(n, 3, 0);
      else if (n <= 27) c0 = 2'b00;
      else if (n <= 32) c0 = per(n - 27, 2, 0);
      else if (n <= 51) c0 = per(n - 33, 2, 0);
      else if (n <= 60) c0 = per(n - 51, 0, 0);
      else              c0 = per(n - 61, 0, 0);
      // ch1: D=1 written at 14 -> active from 16, D=5 via restart at 33,
      // D=2 written with restart at 61 -> restart keeps 5, 2 from 67.
      if      (n <= 16) c1 = per(n, 3, 0);
      else if (n <= 32) c1 = per(n - 16, 1, 0);
      else if (n <= 60) c1 = per(n - 33, 5, 0);
      else if (n <= 67) c1 = per(n - 61, 5, 0);
      else              c1 = per(n - 67, 2, 1);
      // ch2: default, disabled by the write at edge 23.
      if (n <= 23) c2 = per(n, 3, 0);
      else         c2 = 2'b00;
      if      (n <= 22) a = 32'd3;
      else if (n <= 50) a = 32'd2;
      else              a = 32'd0;
    end
    return {a, c2[0], c1[0], c0[0], c2[1], c1[1], c0[1]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push(int e, logic [37:0] v, string nm);
    exp_q.push_back({16'(e), v});
    name_q.push_back(nm);
  endtask

  task automatic step(int ep, int n);
    push(cyc + 1, exp_vec(ep, n), $sformatf("ep%0d_n%0d", ep, n));
    @(posedge clk_in);
    #1;
    cfg_we       = 1'b0;
    sync_restart = 1'b0;
  endtask

  task automatic wr(int ch, int d, logic en);
    cfg_we   = 1'b1;
    cfg_chan = CHW'(ch);
    cfg_div  = CW'(d);
    cfg_en   = en;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [W-1:0] mon_e;
  string        mon_nm;
  logic [37:0]  mon_got;

  always @(negedge clk_in) begin
    while (exp_q.size() > 0 && int'(exp_q[0][53:38]) <= cyc) begin
      mon_e   = exp_q.pop_front();
      mon_nm  = name_q.pop_front();
      mon_got = {active_div_ch0, tick, clk_out};
      checks++;
      if (int'(mon_e[53:38]) != cyc || mon_got !== mon_e[37:0]) begin
        failures++;
        $display("FAIL %s edge=%0d due=%0d: got clk_out=%b tick=%b act=%0d, required clk_out=%b tick=%b act=%0d",
                 mon_nm, cyc, mon_e[53:38], mon_got[2:0], mon_got[5:3], mon_got[37:6],
                 mon_e[2:0], mon_e[5:3], mon_e[37:6]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk_in);
    #1;
    push(cyc, exp_vec(0, 0), "reset_hold");
    rst_n = 1'b1;

    for (int n = 1; n <= 73; n++) begin
      case (n)
        14: wr(1, 1, 1'b1);                          // mid-period reprogram
        22: wr(0, 2, 1'b0);                          // disable ch0 while high
        23: wr(2, 3, 1'b0);                          // park ch2
        27: wr(0, 2, 1'b1);                          // re-enable ch0, D=2
        32: wr(1, 5, 1'b1);
        33: sync_restart = 1'b1;                     // phase alignment
        48: wr(0, 0, 1'b1);                          // write on terminal count
        57: wr(3, 7, 1'b0);                          // out-of-range channel
        61: begin wr(1, 2, 1'b1); sync_restart = 1'b1; end
        default: ;
      endcase
      step(0, n);
    end

    // Asynchronous reset between edges: values must clear before the next
    // rising edge.
    @(posedge clk_in);
    #3;
    rst_n = 1'b0;
    push(cyc, exp_vec(1, 0), "async_reset");
    step(1, 0);
    step(1, 0);
    rst_n = 1'b1;
    for (int n = 1; n <= 9; n++) step(1, n);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk_in);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
